prog_loader: RTL

Boot-time program loader and core-reset sequencer for the single-cycle RV32I core. It holds the core in reset and accepts a framed byte stream on a valid/ready port. It writes the assembled 32-bit words into instruction memory, verifies an XOR checksum, and then releases the core's reset. It sits between the host link (UART receiver) and the instruction-memory write port, and drives the core's RSTn.

---
 rtl/loader_pkg.sv | 27 ++
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_word_assembler.sv | 35 +++
 rtl/prog_loader.sv | 107 ++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared FSM state type and frame constants for prog_loader
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader takes bytes from the host link
  function automatic logic rx_open(state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

  function automatic logic in_load(state_t s);
    return rx_open(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte stream and instruction-memory write port
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - little-endian byte-to-word shifter with running XOR checksum
module word_assembler
  import loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic        word_done
);

  logic [1:0] cnt;

  // Bytes enter at the top so the first byte of a word ends up in [7:0]
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      word <= '0;
      csum <= '0;
      cnt  <= '0;
    end else if (clear) begin
      csum <= '0;
      cnt  <= '0;
    end else if (byte_en) begin
      word <= {byte_in, word[31:8]};
      csum <= csum ^ byte_in;
      cnt  <= cnt + 2'd1;
    end
  end

  assign word_done = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: framed byte stream into imem, checksum verify, core reset release
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          core_rstn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state, state_n;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  words_left;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        csum;
  logic              xfer;
  logic              word_done;
  logic              rx_ready_q;
  logic              imem_we_q;

  assign xfer           = rx_ready_q && bus.rx_valid;
  assign len_full       = {bus.rx_data, len_lo};
  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr;

  word_assembler u_asm (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .clear     ((state == ST_LEN1) && xfer),
    .byte_en   ((state == ST_DATA) && xfer),
    .byte_in   (bus.rx_data),
    .word      (bus.imem_wdata),
    .csum      (csum),
    .word_done (word_done)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: if (start) state_n = ST_LEN0;
      ST_LEN0: if (xfer) state_n = ST_LEN1;
      ST_LEN1: begin
        if (xfer) begin
          if ((len_full == '0) || (32'(len_full) > DEPTH)) state_n = ST_ERROR;
          else                                              state_n = ST_DATA;
        end
      end
      ST_DATA:  if (word_done) state_n = ST_WRITE;
      ST_WRITE: state_n = (words_left == 16'd1) ? ST_CSUM : ST_DATA;
      ST_CSUM: begin
        if (xfer) state_n = (bus.rx_data == csum) ? ST_RUN : ST_ERROR;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      words_left <= '0;
      addr       <= '0;
    end else begin
      state <= state_n;
      if ((state == ST_LEN0) && xfer) len_lo <= bus.rx_data;
      if ((state == ST_LEN1) && xfer) begin
        words_left <= len_full;
        addr       <= '0;
      end
      // Address stays on the last word so a full-depth load never wraps
      if (state == ST_WRITE) begin
        words_left <= words_left - 16'd1;
        if (words_left != 16'd1) addr <= addr + ADDR_W'(1);
      end
    end
  end

  // Outputs decode the next state so they change on the same edge as the FSM
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      core_rstn  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_ready_q <= rx_open(state_n);
      imem_we_q  <= (state_n == ST_WRITE);
      core_rstn  <= (state_n == ST_RUN);
      busy       <= in_load(state_n);
      done       <= (state_n == ST_RUN);
      err        <= (state_n == ST_ERROR);
    end
  end

endmodule
